// File: rtl/register_file_pkg.sv
// Shared types and constants for the renaming register file.
package register_file_pkg;
  typedef logic [31:0] DATA_TYPE;
  typedef logic [4:0]  REG_POS_TYPE;
  typedef logic [4:0]  ROB_ID_TYPE;

  localparam int          REG_NUM   = 32;
  localparam DATA_TYPE    ZERO_WORD = 32'h0;
  localparam REG_POS_TYPE ZERO_REG  = 5'd0;
  localparam ROB_ID_TYPE  ZERO_ROB  = 5'd0;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;
endpackage

// File: rtl/register_read_port.sv
// One combinational source-operand read port with same-cycle commit bypass.
module register_read_port
  import register_file_pkg::*;
(
  input  logic [4:0]  rs_i,
  input  logic [31:0] v_stored_i,
  input  logic [4:0]  q_stored_i,
  input  logic        commit_i,
  input  logic [4:0]  rd_rob_i,
  input  logic [4:0]  q_rob_i,
  input  logic [31:0] v_rob_i,
  output logic [31:0] v_o,
  output logic [4:0]  q_o
);
  logic hit;

  // Forward only when the committing tag is still the live producer of rs.
  assign hit = commit_i && (rd_rob_i == rs_i) && (rs_i != ZERO_REG)
               && (q_stored_i == q_rob_i);

  always_comb begin
    v_o = v_stored_i;
    q_o = q_stored_i;
    if (rs_i == ZERO_REG) begin
      v_o = ZERO_WORD;
      q_o = ZERO_ROB;
    end else if (hit) begin
      v_o = v_rob_i;
      q_o = ZERO_ROB;
    end
  end
endmodule

// File: rtl/register_file.sv
// 32-entry architectural register file with ROB-tag renaming, commit and rollback.
module register_file
  import register_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  rs1_from_dsp,
  input  logic [4:0]  rs2_from_dsp,
  output logic [31:0] V1_to_dsp,
  output logic [31:0] V2_to_dsp,
  output logic [4:0]  Q1_to_dsp,
  output logic [4:0]  Q2_to_dsp,
  input  logic        ena_from_dsp,
  input  logic [4:0]  rd_from_dsp,
  input  logic [4:0]  rob_id_from_dsp,
  input  logic        commit_flag_from_rob,
  input  logic [4:0]  rd_from_rob,
  input  logic [4:0]  Q_from_rob,
  input  logic [31:0] V_from_rob,
  input  logic        rollback_flag_from_rob
);
  logic [31:0] v_q [REG_NUM];
  logic [4:0]  q_q [REG_NUM];

  register_read_port u_rd1 (
    .rs_i       (rs1_from_dsp),
    .v_stored_i (v_q[rs1_from_dsp]),
    .q_stored_i (q_q[rs1_from_dsp]),
    .commit_i   (commit_flag_from_rob),
    .rd_rob_i   (rd_from_rob),
    .q_rob_i    (Q_from_rob),
    .v_rob_i    (V_from_rob),
    .v_o        (V1_to_dsp),
    .q_o        (Q1_to_dsp)
  );

  register_read_port u_rd2 (
    .rs_i       (rs2_from_dsp),
    .v_stored_i (v_q[rs2_from_dsp]),
    .q_stored_i (q_q[rs2_from_dsp]),
    .commit_i   (commit_flag_from_rob),
    .rd_rob_i   (rd_from_rob),
    .q_rob_i    (Q_from_rob),
    .v_rob_i    (V_from_rob),
    .v_o        (V2_to_dsp),
    .q_o        (Q2_to_dsp)
  );

  // Later non-blocking writes win: rename overrides commit Q-clear,
  // rollback overrides both, while commit V-write always lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= ZERO_WORD;
        q_q[i] <= ZERO_ROB;
      end
    end else if (rdy) begin
      if (commit_flag_from_rob && rd_from_rob != ZERO_REG) begin
        v_q[rd_from_rob] <= V_from_rob;
        if (q_q[rd_from_rob] == Q_from_rob) q_q[rd_from_rob] <= ZERO_ROB;
      end
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < REG_NUM; i++) q_q[i] <= ZERO_ROB;
      end else if (ena_from_dsp && rd_from_dsp != ZERO_REG) begin
        q_q[rd_from_dsp] <= rob_id_from_dsp;
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  rs1, rs2;
  logic [31:0] V1, V2;
  logic [4:0]  Q1, Q2;
  logic        ena;
  logic [4:0]  rd_d, rob_id;
  logic        cmt;
  logic [4:0]  rd_r, q_r;
  logic [31:0] v_r;
  logic        rb;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1_from_dsp(rs1), .rs2_from_dsp(rs2),
    .V1_to_dsp(V1), .V2_to_dsp(V2), .Q1_to_dsp(Q1), .Q2_to_dsp(Q2),
    .ena_from_dsp(ena), .rd_from_dsp(rd_d), .rob_id_from_dsp(rob_id),
    .commit_flag_from_rob(cmt), .rd_from_rob(rd_r), .Q_from_rob(q_r),
    .V_from_rob(v_r), .rollback_flag_from_rob(rb)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; state advances on the next rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ena = 0; cmt = 0; rb = 0; rst = 0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] t);
    ena = 1; rd_d = r; rob_id = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] t, input logic [31:0] v);
    cmt = 1; rd_r = r; q_r = t; v_r = v;
  endtask

  task automatic test_reset();
    rdy = 0; rst = 1;
    rename(5, 3); commit(5, 0, 32'hDEAD); rb = 0;
    step();
    rdy = 1; rs1 = 5; rs2 = 0; #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL reset_rs1 got V=%h Q=%0d want V=0 Q=0", V1, Q1);
    end
    checks++;
    if ({V2, Q2} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL reset_rs2 got V=%h Q=%0d want V=0 Q=0", V2, Q2);
    end
  endtask

  task automatic test_rename_commit();
    rs1 = 5; rename(5, 3); #1;
    checks++;
    if (Q1 !== 5'd0) begin
      errors++; $display("FAIL rename_same_cycle_old got Q=%0d want 0", Q1);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd3}) begin
      errors++; $display("FAIL rename_x5 got V=%h Q=%0d want V=0 Q=3", V1, Q1);
    end
    rs2 = 5; commit(5, 3, 32'h1234); #1;
    checks++;
    if ({V1, Q1} !== {32'h1234, 5'd0}) begin
      errors++; $display("FAIL bypass_rs1 got V=%h Q=%0d want V=1234 Q=0", V1, Q1);
    end
    checks++;
    if ({V2, Q2} !== {32'h1234, 5'd0}) begin
      errors++; $display("FAIL bypass_rs2 got V=%h Q=%0d want V=1234 Q=0", V2, Q2);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h1234, 5'd0}) begin
      errors++; $display("FAIL commit_x5 got V=%h Q=%0d want V=1234 Q=0", V1, Q1);
    end
    rename(5, 8); step();
    commit(5, 3, 32'h55); #1;
    checks++;
    if ({V1, Q1} !== {32'h1234, 5'd8}) begin
      errors++; $display("FAIL no_bypass_stale got V=%h Q=%0d want V=1234 Q=8", V1, Q1);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h55, 5'd8}) begin
      errors++; $display("FAIL stale_commit_keeps_q got V=%h Q=%0d want V=55 Q=8", V1, Q1);
    end
  endtask

  task automatic test_younger_rename();
    rename(7, 2); step();
    rename(7, 4); step();
    rs1 = 7; commit(7, 2, 32'hAA); #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd4}) begin
      errors++; $display("FAIL younger_no_bypass got V=%h Q=%0d want V=0 Q=4", V1, Q1);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'hAA, 5'd4}) begin
      errors++; $display("FAIL younger_keep_q got V=%h Q=%0d want V=AA Q=4", V1, Q1);
    end
  endtask

  task automatic test_back_to_back();
    rename(9, 5); step();
    rs1 = 9; rename(9, 6); commit(9, 5, 32'h999); #1;
    checks++;
    if ({V1, Q1} !== {32'h999, 5'd0}) begin
      errors++; $display("FAIL same_cycle_bypass got V=%h Q=%0d want V=999 Q=0", V1, Q1);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h999, 5'd6}) begin
      errors++; $display("FAIL rename_wins_q got V=%h Q=%0d want V=999 Q=6", V1, Q1);
    end
  endtask

  task automatic test_rollback();
    rename(1, 1); step();
    rename(2, 2); step();
    rb = 1; commit(1, 1, 32'h80); rename(3, 3); step();
    rs1 = 1; rs2 = 2; #1;
    checks++;
    if ({V1, Q1} !== {32'h80, 5'd0}) begin
      errors++; $display("FAIL rollback_commit_x1 got V=%h Q=%0d want V=80 Q=0", V1, Q1);
    end
    checks++;
    if ({V2, Q2} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL rollback_x2 got V=%h Q=%0d want V=0 Q=0", V2, Q2);
    end
    rs1 = 3; rs2 = 7; #1;
    checks++;
    if (Q1 !== 5'd0) begin
      errors++; $display("FAIL rollback_drop_rename got Q=%0d want 0", Q1);
    end
    checks++;
    if ({V2, Q2} !== {32'hAA, 5'd0}) begin
      errors++; $display("FAIL rollback_x7 got V=%h Q=%0d want V=AA Q=0", V2, Q2);
    end
    rs1 = 9; rs2 = 5; #1;
    checks++;
    if ({V1, Q1, V2, Q2} !== {32'h999, 5'd0, 32'h55, 5'd0}) begin
      errors++; $display("FAIL rollback_x9_x5 got %h/%0d %h/%0d want 999/0 55/0", V1, Q1, V2, Q2);
    end
  endtask

  task automatic test_x0();
    rs1 = 0; rename(0, 4); commit(0, 0, 32'hFF); #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL x0_same_cycle got V=%h Q=%0d want V=0 Q=0", V1, Q1);
    end
    step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd0}) begin
      errors++; $display("FAIL x0_after got V=%h Q=%0d want V=0 Q=0", V1, Q1);
    end
  endtask

  task automatic test_rdy();
    rename(6, 9); step();
    rdy = 0; rs1 = 6; commit(6, 9, 32'h66); rename(6, 7); #1;
    checks++;
    if ({V1, Q1} !== {32'h66, 5'd0}) begin
      errors++; $display("FAIL stall_bypass got V=%h Q=%0d want V=66 Q=0", V1, Q1);
    end
    step();
    rb = 1; step(); #1;
    checks++;
    if ({V1, Q1} !== {32'h0, 5'd9}) begin
      errors++; $display("FAIL stall_hold got V=%h Q=%0d want V=0 Q=9", V1, Q1);
    end
    rst = 1; step(); #1;
    rs2 = 5;
    #1;
    checks++;
    if ({V1, Q1, V2, Q2} !== {32'h0, 5'd0, 32'h0, 5'd0}) begin
      errors++; $display("FAIL reset_while_stalled got %h/%0d %h/%0d want 0/0 0/0", V1, Q1, V2, Q2);
    end
    rdy = 1;
  endtask

  initial begin
    rst = 0; rdy = 1; rs1 = 0; rs2 = 0;
    ena = 0; rd_d = 0; rob_id = 0;
    cmt = 0; rd_r = 0; q_r = 0; v_r = 0; rb = 0;
    @(negedge clk);
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_back_to_back();
    test_rollback();
    test_x0();
    test_rdy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
